// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_if
//  Description : Handshake and operand bundle between the decode stage, the
//                ALU issue buffer and the downstream execute stage.
//                slave  - issue buffer side (alu_issue)
//                master - upstream/downstream environment side
//  Signals     : flush, in_valid/in_ready, in_opcode, in_funct, in_shamt,
//                in_rs_val, in_rt_val, in_imm, out_valid/out_ready,
//                alu_x, alu_y, alu_op, illegal, illegal_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [2:0]  alu_op;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    modport slave (
        input  flush, in_valid, in_opcode, in_funct, in_shamt,
               in_rs_val, in_rt_val, in_imm, out_ready,
        output in_ready, out_valid, alu_x, alu_y, alu_op, illegal, illegal_cnt
    );

    modport master (
        output flush, in_valid, in_opcode, in_funct, in_shamt,
               in_rs_val, in_rt_val, in_imm, out_ready,
        input  in_ready, out_valid, alu_x, alu_y, alu_op, illegal, illegal_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Decodes MIPS-style R/I-type ALU instructions at acceptance
//                and buffers the decoded {x, y, op, illegal} in a 2-entry
//                FIFO feeding the execute stage. Counts consumed illegal
//                entries (saturating at 255).
//  Ports       : clk   - clock, all state updates on the rising edge
//                rst_n - synchronous active-low reset
//                bus   - alu_issue_if.slave (input handshake + fields,
//                        output handshake + operands, illegal, illegal_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_issue_if.slave  bus
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_SLT = 3'b011;
    localparam logic [2:0] c_OP_SRL = 3'b100;
    localparam logic [2:0] c_OP_SRA = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_ILL = 3'b111;
    localparam logic [7:0] c_ILL_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // Decode of the instruction presented at the input
    // ------------------------------------------------------------------
    logic [31:0] w_dec_x;
    logic [31:0] w_dec_y;
    logic [2:0]  w_dec_op;
    logic        w_dec_ill;

    always_comb begin
        w_dec_x   = '0;
        w_dec_y   = '0;
        w_dec_op  = c_OP_ILL;
        w_dec_ill = 1'b1;
        case (bus.in_opcode)
            6'h00: begin
                case (bus.in_funct)
                    6'h24: begin w_dec_op = c_OP_AND; w_dec_ill = 1'b0; end
                    6'h20: begin w_dec_op = c_OP_ADD; w_dec_ill = 1'b0; end
                    6'h22: begin w_dec_op = c_OP_SUB; w_dec_ill = 1'b0; end
                    6'h2A: begin w_dec_op = c_OP_SLT; w_dec_ill = 1'b0; end
                    6'h02: begin w_dec_op = c_OP_SRL; w_dec_ill = 1'b0; end
                    6'h03: begin w_dec_op = c_OP_SRA; w_dec_ill = 1'b0; end
                    6'h00: begin w_dec_op = c_OP_SLL; w_dec_ill = 1'b0; end
                    default: ;
                endcase
                if (!w_dec_ill) begin
                    // Shifts operate on rt by the shamt field; the rest use rs, rt
                    if (w_dec_op == c_OP_SRL || w_dec_op == c_OP_SRA || w_dec_op == c_OP_SLL) begin
                        w_dec_x = bus.in_rt_val;
                        w_dec_y = {27'd0, bus.in_shamt};
                    end else begin
                        w_dec_x = bus.in_rs_val;
                        w_dec_y = bus.in_rt_val;
                    end
                end
            end
            6'h08: begin   // ADDI
                w_dec_op = c_OP_ADD; w_dec_ill = 1'b0;
                w_dec_x  = bus.in_rs_val;
                w_dec_y  = {{16{bus.in_imm[15]}}, bus.in_imm};
            end
            6'h0C: begin   // ANDI
                w_dec_op = c_OP_AND; w_dec_ill = 1'b0;
                w_dec_x  = bus.in_rs_val;
                w_dec_y  = {16'd0, bus.in_imm};
            end
            6'h0A: begin   // SLTI
                w_dec_op = c_OP_SLT; w_dec_ill = 1'b0;
                w_dec_x  = bus.in_rs_val;
                w_dec_y  = {{16{bus.in_imm[15]}}, bus.in_imm};
            end
            6'h04: begin   // BEQ compares via subtraction
                w_dec_op = c_OP_SUB; w_dec_ill = 1'b0;
                w_dec_x  = bus.in_rs_val;
                w_dec_y  = bus.in_rt_val;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO control
    // ------------------------------------------------------------------
    logic [1:0]  r_count;
    logic        r_wptr;
    logic        r_rptr;
    logic [7:0]  r_ill_cnt;
    logic [31:0] r_x   [2];
    logic [31:0] r_y   [2];
    logic [2:0]  r_op  [2];
    logic        r_ill [2];

    logic [1:0]  w_count_nxt;
    logic        w_wptr_nxt;
    logic        w_rptr_nxt;
    logic [7:0]  w_ill_cnt_nxt;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_push;
    logic        w_pop;

    // in_ready is purely a function of the registered occupancy
    assign w_in_ready  = (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    // Flush suppresses both sides of the handshake for its cycle
    assign w_push = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop  = w_out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        w_count_nxt   = r_count;
        w_wptr_nxt    = r_wptr;
        w_rptr_nxt    = r_rptr;
        w_ill_cnt_nxt = r_ill_cnt;
        if (bus.flush) begin
            w_count_nxt = 2'd0;
            w_wptr_nxt  = 1'b0;
            w_rptr_nxt  = 1'b0;
        end else begin
            if (w_push) w_wptr_nxt = ~r_wptr;
            if (w_pop)  w_rptr_nxt = ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
        if (w_pop && r_ill[r_rptr] && (r_ill_cnt != c_ILL_MAX))
            w_ill_cnt_nxt = r_ill_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_ill_cnt <= 8'd0;
        end else begin
            r_count   <= w_count_nxt;
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_ill_cnt <= w_ill_cnt_nxt;
        end
    end

    // Payload storage needs no reset: occupancy gates every output
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_x[r_wptr]   <= w_dec_x;
            r_y[r_wptr]   <= w_dec_y;
            r_op[r_wptr]  <= w_dec_op;
            r_ill[r_wptr] <= w_dec_ill;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry, forced to zero when empty
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.alu_x       = w_out_valid ? r_x[r_rptr]   : 32'd0;
    assign bus.alu_y       = w_out_valid ? r_y[r_rptr]   : 32'd0;
    assign bus.alu_op      = w_out_valid ? r_op[r_rptr]  : 3'd0;
    assign bus.illegal     = w_out_valid ? r_ill[r_rptr] : 1'b0;
    assign bus.illegal_cnt = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Scoreboard bench for alu_issue. The driver pushes the
//                hand-computed decode of every accepted instruction; the
//                monitor pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [5:0]  opc;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [5:0] opc, input logic [5:0] f,
                                 input logic [4:0] sh, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [15:0] imm,
                                 input logic [31:0] ex, input logic [31:0] ey,
                                 input logic [2:0] eop, input logic eill);
        vec_t v;
        v.opc = opc; v.funct = f; v.shamt = sh; v.rs = rs; v.rt = rt; v.imm = imm;
        v.e.x = ex; v.e.y = ey; v.e.op = eop; v.e.ill = eill;
        return v;
    endfunction

    // Monitor: compare the head on every handshake that will pop at the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt = 0;
        end else if (bus.flush) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got x=0x%08h op=%0d, expected no entry", bus.alu_x, bus.alu_op);
            end else begin
                mon_e = sb.pop_front();
                check("head_x",   bus.alu_x, mon_e.x);
                check("head_y",   bus.alu_y, mon_e.y);
                check("head_op",  32'(bus.alu_op), 32'(mon_e.op));
                check("head_ill", 32'(bus.illegal), 32'(mon_e.ill));
                if (mon_e.ill && exp_cnt < 255) exp_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_opcode = v.opc;
        bus.in_funct  = v.funct;
        bus.in_shamt  = v.shamt;
        bus.in_rs_val = v.rs;
        bus.in_rt_val = v.rt;
        bus.in_imm    = v.imm;
    endtask

    // Hold the instruction until accepted; in_valid is left high
    task automatic send(input vec_t v);
        int   budget;
        logic done;
        budget = 0;
        done   = 1'b0;
        drive(v);
        bus.in_valid = 1'b1;
        while (!done) begin
            if (bus.in_ready) begin
                sb.push_back(v.e);
                done = 1'b1;
            end
            step();
            if (!done) begin
                budget++;
                if (budget > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready=%0d after %0d cycles, expected 1", bus.in_ready, budget);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_alu_x"},     bus.alu_x,          32'd0);
        check({tag, "_alu_y"},     bus.alu_y,          32'd0);
        check({tag, "_alu_op"},    32'(bus.alu_op),    32'd0);
        check({tag, "_illegal"},   32'(bus.illegal),   32'd0);
        check({tag, "_ill_cnt"},   32'(bus.illegal_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v0, v1, v2;

        tbl[0]  = mkv(6'h00, 6'h24, 5'd0,  32'hA5A5_0F0F, 32'h0F0F_FFFF, 16'h0000, 32'hA5A5_0F0F, 32'h0F0F_FFFF, 3'b000, 1'b0);
        tbl[1]  = mkv(6'h00, 6'h20, 5'd0,  32'd5,          32'd7,          16'h0000, 32'd5,          32'd7,          3'b001, 1'b0);
        tbl[2]  = mkv(6'h00, 6'h22, 5'd0,  32'd10,         32'd3,          16'h0000, 32'd10,         32'd3,          3'b010, 1'b0);
        tbl[3]  = mkv(6'h00, 6'h2A, 5'd0,  32'hFFFF_FFFF, 32'd1,          16'h0000, 32'hFFFF_FFFF, 32'd1,          3'b011, 1'b0);
        tbl[4]  = mkv(6'h00, 6'h02, 5'd8,  32'hDEAD_BEEF, 32'h1234_5678, 16'h0000, 32'h1234_5678, 32'd8,          3'b100, 1'b0);
        tbl[5]  = mkv(6'h00, 6'h03, 5'd4,  32'd1,          32'h8000_0000, 16'h0000, 32'h8000_0000, 32'd4,          3'b101, 1'b0);
        tbl[6]  = mkv(6'h00, 6'h00, 5'd31, 32'd2,          32'd1,          16'h0000, 32'd1,          32'h0000_001F, 3'b110, 1'b0);
        tbl[7]  = mkv(6'h08, 6'h00, 5'd0,  32'd1,          32'd0,          16'hFFFF, 32'd1,          32'hFFFF_FFFF, 3'b001, 1'b0);
        tbl[8]  = mkv(6'h0C, 6'h00, 5'd0,  32'd3,          32'd0,          16'hFFFF, 32'd3,          32'h0000_FFFF, 3'b000, 1'b0);
        tbl[9]  = mkv(6'h0A, 6'h00, 5'd0,  32'd5,          32'd0,          16'h8000, 32'd5,          32'hFFFF_8000, 3'b011, 1'b0);
        tbl[10] = mkv(6'h0A, 6'h00, 5'd0,  32'd6,          32'd0,          16'h7FFF, 32'd6,          32'h0000_7FFF, 3'b011, 1'b0);
        tbl[11] = mkv(6'h04, 6'h00, 5'd0,  32'd9,          32'd9,          16'h1234, 32'd9,          32'd9,          3'b010, 1'b0);
        tbl[12] = mkv(6'h00, 6'h01, 5'd3,  32'd5,          32'd6,          16'h0000, 32'd0,          32'd0,          3'b111, 1'b1);
        tbl[13] = mkv(6'h2B, 6'h20, 5'd0,  32'd1,          32'd2,          16'h0004, 32'd0,          32'd0,          3'b111, 1'b1);

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(mkv(6'h0, 6'h0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0, 3'd0, 1'b0));
        repeat (3) step();
        check_reset_outputs("rst");

        // First accept on the first edge with reset released
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(tbl[1]);
        bus.in_valid = 1'b0;
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_op",    32'(bus.alu_op),    32'd1);
        check("lat_x",     bus.alu_x,          32'd5);
        check("lat_y",     bus.alu_y,          32'd7);
        step();
        check("lat_drained", 32'(bus.out_valid), 32'd0);

        // Decode table streamed back-to-back
        for (int i = 0; i < 14; i++) send(tbl[i]);
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("tbl_ill_cnt", 32'(bus.illegal_cnt), 32'd2);

        // Backpressure: only two entries fit
        bus.out_ready = 1'b0;
        v0 = mkv(6'h00, 6'h20, 5'd0, 32'd11, 32'd22, 16'd0, 32'd11, 32'd22, 3'b001, 1'b0);
        v1 = mkv(6'h00, 6'h22, 5'd0, 32'd33, 32'd44, 16'd0, 32'd33, 32'd44, 3'b010, 1'b0);
        v2 = mkv(6'h00, 6'h24, 5'd0, 32'd55, 32'd66, 16'd0, 32'd55, 32'd66, 3'b000, 1'b0);
        check("bp_ready0", 32'(bus.in_ready), 32'd1);
        send(v0);
        check("bp_ready1", 32'(bus.in_ready), 32'd1);
        send(v1);
        check("bp_ready2", 32'(bus.in_ready), 32'd0);
        check("bp_valid",  32'(bus.out_valid), 32'd1);
        drive(v2);
        step();
        step();
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_hold_x", bus.alu_x, 32'd11);
        check("bp_hold_y", bus.alu_y, 32'd22);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_x",     bus.alu_x,          32'd33);
        step();
        check("bp_empty",       32'(bus.out_valid), 32'd0);
        check("bp_ready_again", 32'(bus.in_ready),  32'd1);

        // Steady push+pop at occupancy one
        bus.out_ready = 1'b0;
        send(mkv(6'h00, 6'h20, 5'd0, 32'd100, 32'd200, 16'd0, 32'd100, 32'd200, 3'b001, 1'b0));
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(mkv(6'h00, 6'h20, 5'd0, 32'(100 + i), 32'(200 + i), 16'd0,
                     32'(100 + i), 32'(200 + i), 3'b001, 1'b0));
            check("s1_ready",  32'(bus.in_ready),  32'd1);
            check("s1_valid",  32'(bus.out_valid), 32'd1);
            check("s1_head_x", bus.alu_x,          32'(100 + i));
        end
        // Flush with a pending instruction: nothing kept, nothing accepted
        drive(mkv(6'h00, 6'h20, 5'd0, 32'd999, 32'd1, 16'd0, 32'd0, 32'd0, 3'd0, 1'b0));
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_ready", 32'(bus.in_ready),  32'd1);
        check("fl_x",     bus.alu_x,          32'd0);
        step();
        check("fl_none",    32'(bus.out_valid),   32'd0);
        check("fl_ill_cnt", 32'(bus.illegal_cnt), 32'd2);

        // Illegal stream saturates the counter
        for (int i = 0; i < 300; i++)
            send(mkv(6'h3F, 6'(i), 5'(i), 32'(i), ~32'(i), 16'(i), 32'd0, 32'd0, 3'b111, 1'b1));
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("ill_sat",   32'(bus.illegal_cnt), 32'd255);
        check("ill_model", 32'(bus.illegal_cnt), 32'(exp_cnt));

        // Reset in the middle of a stream
        for (int i = 0; i < 4; i++)
            send(mkv(6'h3F, 6'd0, 5'd0, 32'(i), 32'd0, 16'd0, 32'd0, 32'd0, 3'b111, 1'b1));
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_rst");
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        send(tbl[2]);
        bus.in_valid = 1'b0;
        repeat (2) step();
        check("post_rst_ill_cnt", 32'(bus.illegal_cnt), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-003 flush  input  1  synchronous discard of all buffered entries.
REQ-004 in_valid  input  1  upstream presents an instruction.
REQ-005 in_ready  output  1  block can accept this cycle.
REQ-006 in_opcode  input  6  instruction opcode field.
REQ-007 in_funct  input  6  R-type funct field.
REQ-008 in_shamt  input  5  R-type shift amount.
REQ-009 in_rs_val  input  32  rs register value.
REQ-010 in_rt_val  input  32  rt register value.
REQ-011 in_imm  input  16  I-type immediate.
REQ-012 out_valid  output  1  head entry is valid and drives alu_x, alu_y and alu_op.
REQ-013 out_ready  input  1  downstream execute stage consumes the head entry.
REQ-014 alu_x  output  32  ALU x operand.
REQ-015 alu_y  output  32  ALU y operand.
REQ-016 alu_op  output  3  ALU op: 000 AND, 001 ADD, 010 SUB, 011 SLT, 100 SRL, 101 SRA, 110 SLL, 111 reserved.
REQ-017 illegal  output  1  head entry decoded as unsupported.
REQ-018 illegal_cnt  output  8  saturating count of illegal entries consumed.

Function
REQ-019 The block SHALL decode each instruction at acceptance and store the decoded {x, y, op, illegal} in a 2-entry FIFO.
REQ-020 The opcode 0x00 decode SHALL map funct to op and operands as follows: 0x24→000, 0x20→001, 0x22→010, 0x2A→011, each with x=rs, y=rt.
REQ-021 The opcode 0x00 decode SHALL map funct 0x02→100, 0x03→101, 0x00→110, each with x=rt, y=zero-extended shamt.
REQ-022 The I-type decode SHALL be: ADDI 0x08→001 with y=sign-extended imm; ANDI 0x0C→000 with y=zero-extended imm; SLTI 0x0A→011 with y=sign-extended imm; BEQ 0x04→010 with y=rt; x=rs in all four cases.
REQ-023 Any other opcode, or any other funct under opcode 0x00, SHALL decode to op=111, x=0, y=0 and illegal=1.
REQ-024 in_ready SHALL equal (count<2) and SHALL depend only on registered state, not on out_ready.
REQ-025 An entry SHALL be accepted when in_valid&&in_ready on the rising edge.
REQ-026 An entry SHALL be popped when out_valid&&out_ready on the rising edge.
REQ-027 out_valid SHALL equal (count>0); alu_x, alu_y, alu_op and illegal SHALL come from the head entry and SHALL be 0 when count=0.
REQ-028 Latency: an entry accepted at edge N into an empty FIFO SHALL appear on the outputs after edge N, i.e. in cycle N+1.
REQ-029 A simultaneous push and pop with count=1 SHALL leave count=1 with the new entry at the head.
REQ-030 With count=2 there SHALL be no push (in_ready=0); a pop SHALL leave count=1, and the old tail SHALL become the head.
REQ-031 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 Read and write pointers SHALL be 1 bit each and SHALL wrap 1→0.
REQ-033 flush=1 SHALL set count=0 and both pointers to 0, and SHALL suppress any push or pop in that cycle.
REQ-034 illegal_cnt SHALL increment by 1 on each pop of an entry with illegal=1, SHALL saturate at 255, and SHALL NOT be cleared by flush.

Reset
REQ-035 While rst_n=0 at a rising edge: count=0, pointers=0, illegal_cnt=0, out_valid=0, in_ready=1, alu_x=0, alu_y=0, alu_op=000, illegal=0.
REQ-036 Reset SHALL have priority over flush, push and pop, and SHALL discard any in-flight entries.
REQ-037 The first accept SHALL be possible at the first edge with rst_n=1.

Verification
REQ-038 Reset, then ADD (op 0x00, funct 0x20), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_op=001, alu_x=5, alu_y=7; one cycle later out_valid=0.
REQ-039 ADDI, rs=1, imm=0xFFFF -> alu_op=001, alu_y=0xFFFFFFFF; ANDI with imm=0xFFFF -> alu_op=000, alu_y=0x0000FFFF.
REQ-040 SRA, rt=0x80000000, shamt=4 -> alu_op=101, alu_x=0x80000000, alu_y=4.
REQ-041 out_ready=0, push 3 instructions back-to-back -> 2 accepted, in_ready=0 after the 2nd; raise out_ready -> entries emerge in order, one per cycle.
REQ-042 count=1 with simultaneous push and pop for 10 cycles -> count stays 1, all 10 entries delivered in order; then flush with in_valid=1 -> out_valid=0 next cycle, nothing accepted.
REQ-043 Feed 300 illegal opcodes (0x3F) with out_ready=1 -> each shows alu_op=111, illegal=1; illegal_cnt ends at 255; drive rst_n=0 mid-stream -> all outputs return to reset values at that edge.
